// File: rtl/trig_pulse_queue.sv
// trig_pulse_queue: counts trigger pulses and reissues them downstream with valid/ready and a programmable gap.
// Optional build macro TRIG_PULSE_QUEUE_STATS_EN enables the saturating dropped-pulse counter.
module trig_pulse_queue #(
    parameter int DEPTH_BITS = 4,
    parameter int GAP_BITS   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pulse_i,
    input  logic                  clear_i,
    input  logic [GAP_BITS-1:0]   spacing_i,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DEPTH_BITS-1:0] pending,
    output logic                  overflow,
    output logic [7:0]            dropped_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

    state_t                r_state, w_state_nxt;
    logic [DEPTH_BITS-1:0] r_pending, w_pending_nxt;
    logic [GAP_BITS-1:0]   r_gap, w_gap_nxt;
    logic                  r_overflow;
    logic                  w_accept, w_full, w_keep, w_drop;

    assign w_accept = (r_state == ISSUE) & out_ready;
    assign w_full   = &r_pending;
    assign w_keep   = pulse_i & (~w_full | w_accept);
    assign w_drop   = pulse_i & w_full & ~w_accept;

    // queue depth: a kept pulse and an accept in the same cycle cancel out
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_keep && !w_accept)
            w_pending_nxt = r_pending + 1'b1;
        else if (w_accept && !w_keep && |r_pending)
            w_pending_nxt = r_pending - 1'b1;
    end

    // issue sequencing: wait for work, hold valid until accepted, then idle for the sampled gap
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        case (r_state)
            IDLE: w_state_nxt = |r_pending ? ISSUE : IDLE;
            ISSUE: begin
                if (w_accept) begin
                    if (|spacing_i) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = spacing_i;
                    end else begin
                        w_state_nxt = |w_pending_nxt ? ISSUE : IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap <= GAP_BITS'(1)) begin
                    w_state_nxt = |w_pending_nxt ? ISSUE : IDLE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // state, depth, gap and sticky overflow registers; clear wins over everything
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_gap      <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_gap      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_gap      <= w_gap_nxt;
            r_overflow <= r_overflow | w_drop;
        end
    end

`ifdef TRIG_PULSE_QUEUE_STATS_EN
    logic [7:0] r_dropped;

    // saturating count of pulses lost to a full queue
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_dropped <= 8'd0;
        else if (clear_i)
            r_dropped <= 8'd0;
        else if (w_drop && r_dropped != 8'hFF)
            r_dropped <= r_dropped + 8'd1;
    end

    assign dropped_cnt = r_dropped;
`else
    assign dropped_cnt = 8'd0;
`endif

    assign out_valid = (r_state == ISSUE);
    assign pending   = r_pending;
    assign overflow  = r_overflow;
endmodule
